// File: rtl/conv_bank_scheduler_pkg.sv
// conv_bank_scheduler_pkg
// Shared definitions for the ping-pong feature-map bank scheduler:
//   - bank state encodings (EMPTY/WRITING/FULL/READING)
//   - number of banks (NBANK)
//   - enum view of the bank state used by the per-bank FSM
package conv_bank_scheduler_pkg;

  localparam int NBANK = 2;

  typedef logic [1:0] bank_state_t;

  localparam bank_state_t EMPTY   = 2'b00;
  localparam bank_state_t WRITING = 2'b01;
  localparam bank_state_t FULL    = 2'b10;
  localparam bank_state_t READING = 2'b11;

  typedef enum logic [1:0] {
    BANK_EMPTY   = EMPTY,
    BANK_WRITING = WRITING,
    BANK_FULL    = FULL,
    BANK_READING = READING
  } bank_state_e;

endpackage

// File: rtl/conv_bank_scheduler_bank_state_fsm.sv
// bank_state_fsm
// Lifecycle tracker for one feature-map bank. Only the legal ring
// EMPTY -> WRITING -> FULL -> READING -> EMPTY is ever taken; any strobe
// that does not match the current state is ignored.
// Ports:
//   clk        in   clock, state on rising edge
//   rst_n      in   asynchronous active-low reset
//   clr        in   synchronous clear back to EMPTY, highest priority
//   start_wr   in   write grant issued for this bank
//   done_wr    in   write of this bank finished
//   start_rd   in   read grant issued for this bank
//   done_rd    in   read of this bank finished
//   state      out  registered bank state
//   state_next out  state the bank takes at the next edge
module bank_state_fsm
  import conv_bank_scheduler_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       start_wr,
  input  logic       done_wr,
  input  logic       start_rd,
  input  logic       done_rd,
  output logic [1:0] state,
  output logic [1:0] state_next
);

  bank_state_e state_reg;
  bank_state_e state_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BANK_EMPTY;
    end else begin
      state_reg <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_reg;
    if (clr) begin
      state_nxt = BANK_EMPTY;
    end else begin
      case (state_reg)
        BANK_EMPTY:   if (start_wr) state_nxt = BANK_WRITING;
        BANK_WRITING: if (done_wr)  state_nxt = BANK_FULL;
        BANK_FULL:    if (start_rd) state_nxt = BANK_READING;
        BANK_READING: if (done_rd)  state_nxt = BANK_EMPTY;
        default:                    state_nxt = BANK_EMPTY;
      endcase
    end
  end

  assign state      = state_reg;
  assign state_next = state_nxt;

endmodule

// File: rtl/conv_bank_scheduler.sv
// conv_bank_scheduler
// Ping-pong scheduler for two feature-map RAM banks. The write side and the
// read side each get exclusive use of one bank; frames strictly alternate
// 0,1,0,1,... on both sides. oRD_CLR pulses with every new read grant so the
// read controller's nested counters restart per frame.
// Ports:
//   iCLK       in   clock
//   iRSTn      in   asynchronous active-low reset
//   iCLR       in   synchronous clear, same effect as reset, highest priority
//   iWR_REQ    in   write side requests a bank (level)
//   iWR_DONE   in   pulse: granted write bank fully written
//   oWR_GNT    out  write side owns bank oWR_SEL
//   oWR_SEL    out  bank granted to write side
//   iRD_REQ    in   read side requests a bank (level)
//   iRD_DONE   in   pulse: read of granted bank finished
//   oRD_GNT    out  read side owns bank oRD_SEL
//   oRD_SEL    out  bank granted to read side
//   oRD_CLR    out  one-cycle pulse coincident with oRD_GNT rising
//   oFULL      out  both banks FULL
//   oEMPTY     out  both banks EMPTY
//   oFRAME_CNT out  frames consumed, modulo 2^FCW
//   oERR       out  sticky protocol error (DONE without a grant)
module conv_bank_scheduler
  import conv_bank_scheduler_pkg::*;
#(
  parameter int FCW = 8
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  input  logic           iCLR,
  input  logic           iWR_REQ,
  input  logic           iWR_DONE,
  output logic           oWR_GNT,
  output logic           oWR_SEL,
  input  logic           iRD_REQ,
  input  logic           iRD_DONE,
  output logic           oRD_GNT,
  output logic           oRD_SEL,
  output logic           oRD_CLR,
  output logic           oFULL,
  output logic           oEMPTY,
  output logic [FCW-1:0] oFRAME_CNT,
  output logic           oERR
);

  logic [1:0] bank_state [NBANK];
  logic [1:0] bank_next  [NBANK];

  logic           wr_ptr_reg;
  logic           rd_ptr_reg;
  logic           wr_gnt_reg;
  logic           wr_sel_reg;
  logic           rd_gnt_reg;
  logic           rd_sel_reg;
  logic           rd_clr_reg;
  logic           full_reg;
  logic           empty_reg;
  logic [FCW-1:0] frame_cnt_reg;
  logic           err_reg;

  logic wr_start;
  logic wr_done;
  logic rd_start;
  logic rd_done;
  logic wr_err;
  logic rd_err;
  logic full_next;
  logic empty_next;

  // Eligibility looks only at registered bank state, so a bank released at
  // one edge can be granted to the other side no earlier than the next edge.
  assign wr_start = ~iCLR & ~wr_gnt_reg & iWR_REQ & (bank_state[wr_ptr_reg] == EMPTY);
  assign rd_start = ~iCLR & ~rd_gnt_reg & iRD_REQ & (bank_state[rd_ptr_reg] == FULL);
  assign wr_done  = ~iCLR & iWR_DONE & wr_gnt_reg;
  assign rd_done  = ~iCLR & iRD_DONE & rd_gnt_reg;
  assign wr_err   = iWR_DONE & ~wr_gnt_reg;
  assign rd_err   = iRD_DONE & ~rd_gnt_reg;

  // Completions are routed by the granted select, which equals the pointer
  // for the whole grant; start and done on one side are mutually exclusive.
  generate
    for (genvar gi = 0; gi < NBANK; gi++) begin : g_bank
      bank_state_fsm u_bank (
        .clk        (iCLK),
        .rst_n      (iRSTn),
        .clr        (iCLR),
        .start_wr   (wr_start && (wr_ptr_reg == 1'(gi))),
        .done_wr    (wr_done  && (wr_sel_reg == 1'(gi))),
        .start_rd   (rd_start && (rd_ptr_reg == 1'(gi))),
        .done_rd    (rd_done  && (rd_sel_reg == 1'(gi))),
        .state      (bank_state[gi]),
        .state_next (bank_next[gi])
      );
    end
  endgenerate

  always_comb begin
    full_next  = 1'b1;
    empty_next = 1'b1;
    for (int i = 0; i < NBANK; i++) begin
      if (bank_next[i] != FULL)  full_next  = 1'b0;
      if (bank_next[i] != EMPTY) empty_next = 1'b0;
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_gnt_reg    <= 1'b0;
      wr_sel_reg    <= 1'b0;
      rd_gnt_reg    <= 1'b0;
      rd_sel_reg    <= 1'b0;
      rd_clr_reg    <= 1'b0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      frame_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else if (iCLR) begin
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      wr_gnt_reg    <= 1'b0;
      wr_sel_reg    <= 1'b0;
      rd_gnt_reg    <= 1'b0;
      rd_sel_reg    <= 1'b0;
      rd_clr_reg    <= 1'b0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      frame_cnt_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (wr_start) begin
        wr_gnt_reg <= 1'b1;
        wr_sel_reg <= wr_ptr_reg;
      end
      if (wr_done) begin
        wr_gnt_reg <= 1'b0;
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (rd_start) begin
        rd_gnt_reg <= 1'b1;
        rd_sel_reg <= rd_ptr_reg;
      end
      if (rd_done) begin
        rd_gnt_reg    <= 1'b0;
        rd_ptr_reg    <= ~rd_ptr_reg;
        frame_cnt_reg <= frame_cnt_reg + FCW'(1);
      end
      rd_clr_reg <= rd_start;
      full_reg   <= full_next;
      empty_reg  <= empty_next;
      err_reg    <= err_reg | wr_err | rd_err;
    end
  end

  assign oWR_GNT    = wr_gnt_reg;
  assign oWR_SEL    = wr_sel_reg;
  assign oRD_GNT    = rd_gnt_reg;
  assign oRD_SEL    = rd_sel_reg;
  assign oRD_CLR    = rd_clr_reg;
  assign oFULL      = full_reg;
  assign oEMPTY     = empty_reg;
  assign oFRAME_CNT = frame_cnt_reg;
  assign oERR       = err_reg;

endmodule

// File: tb/tb_conv_bank_scheduler.sv
// tb_conv_bank_scheduler
// Drives two scheduler instances (FCW=8 and FCW=2) from the same stimulus and
// compares them against a frame-count model: W frames written, R frames read,
// frame f lives in bank f%2, a write may start while W-R<2, a read while R<W.
module tb_conv_bank_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic wr_req = 1'b0, wr_done = 1'b0, rd_req = 1'b0, rd_done = 1'b0;

  logic a_wr_gnt, a_wr_sel, a_rd_gnt, a_rd_sel, a_rd_clr, a_full, a_empty, a_err;
  logic [7:0] a_cnt;
  logic b_wr_gnt, b_wr_sel, b_rd_gnt, b_rd_sel, b_rd_clr, b_full, b_empty, b_err;
  logic [1:0] b_cnt;

  int n_checks = 0;
  int n_fail = 0;

  // reference model
  int   m_w, m_r;
  logic m_wr_busy, m_wr_sel, m_rd_busy, m_rd_sel, m_rd_clr, m_err;

  conv_bank_scheduler #(.FCW(8)) dut_a (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr),
    .iWR_REQ(wr_req), .iWR_DONE(wr_done), .oWR_GNT(a_wr_gnt), .oWR_SEL(a_wr_sel),
    .iRD_REQ(rd_req), .iRD_DONE(rd_done), .oRD_GNT(a_rd_gnt), .oRD_SEL(a_rd_sel),
    .oRD_CLR(a_rd_clr), .oFULL(a_full), .oEMPTY(a_empty), .oFRAME_CNT(a_cnt), .oERR(a_err)
  );

  conv_bank_scheduler #(.FCW(2)) dut_b (
    .iCLK(clk), .iRSTn(rst_n), .iCLR(clr),
    .iWR_REQ(wr_req), .iWR_DONE(wr_done), .oWR_GNT(b_wr_gnt), .oWR_SEL(b_wr_sel),
    .iRD_REQ(rd_req), .iRD_DONE(rd_done), .oRD_GNT(b_rd_gnt), .oRD_SEL(b_rd_sel),
    .oRD_CLR(b_rd_clr), .oFULL(b_full), .oEMPTY(b_empty), .oFRAME_CNT(b_cnt), .oERR(b_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_w = 0; m_r = 0;
    m_wr_busy = 1'b0; m_wr_sel = 1'b0;
    m_rd_busy = 1'b0; m_rd_sel = 1'b0;
    m_rd_clr = 1'b0; m_err = 1'b0;
  endtask

  // Applies one clock edge worth of rules using the inputs currently driven.
  task automatic model_edge();
    logic ws, rs, wd, rdn;
    if (!rst_n || clr) begin
      model_reset();
    end else begin
      wd = wr_done && m_wr_busy;
      rdn = rd_done && m_rd_busy;
      if (wr_done && !m_wr_busy) m_err = 1'b1;
      if (rd_done && !m_rd_busy) m_err = 1'b1;
      ws = !m_wr_busy && wr_req && (m_w - m_r < 2);
      rs = !m_rd_busy && rd_req && (m_r < m_w);
      if (wd) begin m_w++; m_wr_busy = 1'b0; end
      if (ws) begin m_wr_busy = 1'b1; m_wr_sel = 1'(m_w % 2); end
      if (rdn) begin m_r++; m_rd_busy = 1'b0; end
      if (rs) begin m_rd_busy = 1'b1; m_rd_sel = 1'(m_r % 2); end
      m_rd_clr = rs;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [25:0] obs_vec();
    return {a_wr_gnt, a_wr_sel, a_rd_gnt, a_rd_sel, a_rd_clr, a_full, a_empty, a_err, a_cnt,
            b_wr_gnt, b_wr_sel, b_rd_gnt, b_rd_sel, b_rd_clr, b_full, b_empty, b_err, b_cnt};
  endfunction

  function automatic logic [25:0] exp_vec();
    logic fl, em;
    logic [7:0] flags;
    fl = (m_w - m_r == 2) && !m_rd_busy;
    em = (m_w == m_r) && !m_wr_busy;
    flags = {m_wr_busy, m_wr_sel, m_rd_busy, m_rd_sel, m_rd_clr, fl, em, m_err};
    return {flags, 8'(m_r % 256), flags, 2'(m_r % 4)};
  endfunction

  task automatic do_clr();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  task automatic write_frame();
    wr_req = 1'b1; step(); wr_req = 1'b0;
    wr_done = 1'b1; step(); wr_done = 1'b0;
  endtask

  task automatic read_frame();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    rd_done = 1'b1; step(); rd_done = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL reset_vec: got %h want %h", obs_vec(), exp_vec());
    end
    n_checks++;
    if ({a_wr_gnt, a_rd_gnt, a_rd_clr, a_full, a_empty, a_err, a_cnt} !== {6'b000010, 8'd0}) begin
      n_fail++; $display("FAIL reset_outputs: got gnt=%b/%b clr=%b full=%b empty=%b err=%b cnt=%0d want 0/0 0 0 1 0 0",
                         a_wr_gnt, a_rd_gnt, a_rd_clr, a_full, a_empty, a_err, a_cnt);
    end
  endtask

  task automatic test_first_write();
    wr_req = 1'b1; step();
    n_checks++;
    if ({a_wr_gnt, a_wr_sel} !== 2'b10) begin
      n_fail++; $display("FAIL first_wr_grant: got gnt=%b sel=%b want gnt=1 sel=0", a_wr_gnt, a_wr_sel);
    end
    wr_req = 1'b0; wr_done = 1'b1; step(); wr_done = 1'b0;
    n_checks++;
    if ({a_wr_gnt, a_full, a_empty} !== 3'b000) begin
      n_fail++; $display("FAIL first_wr_release: got gnt=%b full=%b empty=%b want 0 0 0", a_wr_gnt, a_full, a_empty);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL first_wr_vec: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_ping_pong();
    do_clr();
    for (int f = 0; f < 4; f++) begin
      wr_req = 1'b1; step(); wr_req = 1'b0;
      n_checks++;
      if ({a_wr_gnt, a_wr_sel} !== {1'b1, 1'(f % 2)}) begin
        n_fail++; $display("FAIL pp_wr_sel f%0d: got gnt=%b sel=%b want 1 %0d", f, a_wr_gnt, a_wr_sel, f % 2);
      end
      wr_done = 1'b1; step(); wr_done = 1'b0;
      rd_req = 1'b1; step(); rd_req = 1'b0;
      n_checks++;
      if ({a_rd_gnt, a_rd_clr, a_rd_sel} !== {2'b11, 1'(f % 2)}) begin
        n_fail++; $display("FAIL pp_rd_grant f%0d: got gnt=%b clr=%b sel=%b want 1 1 %0d", f, a_rd_gnt, a_rd_clr, a_rd_sel, f % 2);
      end
      step();
      n_checks++;
      if ({a_rd_gnt, a_rd_clr} !== 2'b10) begin
        n_fail++; $display("FAIL pp_rd_clr_width f%0d: got gnt=%b clr=%b want 1 0", f, a_rd_gnt, a_rd_clr);
      end
      rd_done = 1'b1; step(); rd_done = 1'b0;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL pp_vec f%0d: got %h want %h", f, obs_vec(), exp_vec());
      end
    end
    n_checks++;
    if (a_cnt !== 8'd4) begin
      n_fail++; $display("FAIL pp_frame_cnt: got %0d want 4", a_cnt);
    end
  endtask

  task automatic test_backpressure();
    do_clr();
    write_frame();
    write_frame();
    n_checks++;
    if ({a_full, a_empty} !== 2'b10) begin
      n_fail++; $display("FAIL bp_full: got full=%b empty=%b want 1 0", a_full, a_empty);
    end
    wr_req = 1'b1;
    repeat (3) step();
    n_checks++;
    if (a_wr_gnt !== 1'b0) begin
      n_fail++; $display("FAIL bp_third_wr_blocked: got gnt=%b want 0", a_wr_gnt);
    end
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_checks++;
    if ({a_rd_gnt, a_full, a_wr_gnt} !== 3'b100) begin
      n_fail++; $display("FAIL bp_rd_grant: got rd_gnt=%b full=%b wr_gnt=%b want 1 0 0", a_rd_gnt, a_full, a_wr_gnt);
    end
    rd_done = 1'b1; step(); rd_done = 1'b0;
    n_checks++;
    if (a_wr_gnt !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_bypass_wr: got gnt=%b want 0", a_wr_gnt);
    end
    step();
    n_checks++;
    if ({a_wr_gnt, a_wr_sel} !== 2'b10) begin
      n_fail++; $display("FAIL bp_wr_grant_late: got gnt=%b sel=%b want 1 0", a_wr_gnt, a_wr_sel);
    end
    wr_req = 1'b0;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL bp_vec: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_no_bypass();
    do_clr();
    wr_req = 1'b1; step(); wr_req = 1'b0;
    rd_req = 1'b1; step();
    n_checks++;
    if (a_rd_gnt !== 1'b0) begin
      n_fail++; $display("FAIL nb_rd_early: got gnt=%b want 0", a_rd_gnt);
    end
    wr_done = 1'b1; step(); wr_done = 1'b0;
    n_checks++;
    if ({a_wr_gnt, a_rd_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL nb_release_edge: got wr_gnt=%b rd_gnt=%b want 0 0", a_wr_gnt, a_rd_gnt);
    end
    step(); rd_req = 1'b0;
    n_checks++;
    if ({a_rd_gnt, a_rd_clr, a_rd_sel} !== 3'b110) begin
      n_fail++; $display("FAIL nb_rd_grant: got gnt=%b clr=%b sel=%b want 1 1 0", a_rd_gnt, a_rd_clr, a_rd_sel);
    end
  endtask

  task automatic test_error_clear();
    do_clr();
    rd_done = 1'b1; step(); rd_done = 1'b0;
    n_checks++;
    if ({a_err, a_cnt} !== {1'b1, 8'd0}) begin
      n_fail++; $display("FAIL err_set: got err=%b cnt=%0d want 1 0", a_err, a_cnt);
    end
    repeat (3) step();
    wr_req = 1'b1; step(); wr_req = 1'b0;
    n_checks++;
    if ({a_err, a_wr_gnt} !== 2'b11) begin
      n_fail++; $display("FAIL err_sticky: got err=%b wr_gnt=%b want 1 1", a_err, a_wr_gnt);
    end
    clr = 1'b1; wr_done = 1'b1; step(); clr = 1'b0; wr_done = 1'b0;
    n_checks++;
    if ({a_wr_gnt, a_wr_sel, a_rd_gnt, a_rd_sel, a_rd_clr, a_full, a_empty, a_err, a_cnt} !== {8'b00000010, 8'd0}) begin
      n_fail++; $display("FAIL clr_values: got %b_%0d want 00000010_0",
                         {a_wr_gnt, a_wr_sel, a_rd_gnt, a_rd_sel, a_rd_clr, a_full, a_empty, a_err}, a_cnt);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL clr_vec: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_fcw2_wrap();
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_clr();
    for (int f = 0; f < 5; f++) begin
      write_frame();
      read_frame();
      n_checks++;
      if ({b_cnt, a_cnt} !== {seq[f], 8'(f + 1)}) begin
        n_fail++; $display("FAIL fcw2_cnt f%0d: got b=%0d a=%0d want b=%0d a=%0d", f, b_cnt, a_cnt, seq[f], f + 1);
      end
    end
  endtask

  task automatic test_random();
    do_clr();
    for (int i = 0; i < 800; i++) begin
      wr_req = ($urandom_range(0, 3) != 0);
      rd_req = ($urandom_range(0, 3) != 0);
      wr_done = m_wr_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
      rd_done = m_rd_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 149) == 0);
      clr = ($urandom_range(0, 249) == 0);
      step();
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random_vec cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    wr_req = 1'b0; rd_req = 1'b0; wr_done = 1'b0; rd_done = 1'b0; clr = 1'b0;
  endtask

  task automatic test_async_reset();
    do_clr();
    write_frame();
    rd_req = 1'b1; step(); rd_req = 1'b0;
    n_checks++;
    if (a_rd_gnt !== 1'b1) begin
      n_fail++; $display("FAIL ar_rd_gnt_before: got %b want 1", a_rd_gnt);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if ({a_rd_gnt, a_empty, b_rd_gnt, b_empty} !== 4'b0101) begin
      n_fail++; $display("FAIL ar_immediate: got rd_gnt=%b empty=%b (fcw2 %b %b) want 0 1", a_rd_gnt, a_empty, b_rd_gnt, b_empty);
    end
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL ar_vec: got %h want %h", obs_vec(), exp_vec());
    end
    @(negedge clk);
    rst_n = 1'b1;
    wr_req = 1'b1; step(); wr_req = 1'b0;
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL ar_after_vec: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_first_write();
    test_ping_pong();
    test_backpressure();
    test_no_bypass();
    test_error_clear();
    test_fcw2_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_bank_scheduler.md
# conv_bank_scheduler

Ping-pong buffer scheduler for the two feature-map RAM banks between a layer's write side and the next convolution's read side. It grants the write controller exclusive use of one bank and the read controller exclusive use of the other. It tracks each bank as EMPTY/WRITING/FULL/READING and enforces strict in-order alternation of frames. It emits a one-cycle clear pulse so the read controller's nested counters restart at the start of every granted frame.

## Interface
Parameters:
- FCW, 8, width of the consumed-frame counter

Ports:
- iCLK  in  1  system clock, all state on rising edge
- iRSTn  in  1  asynchronous active-low reset
- iCLR  in  1  synchronous clear; same effect as reset, wins over all other inputs
- iWR_REQ  in  1  write side requests a bank (level)
- iWR_DONE  in  1  one-cycle pulse: granted write bank fully written
- oWR_GNT  out  1  write side owns bank oWR_SEL
- oWR_SEL  out  1  bank index granted to write side
- iRD_REQ  in  1  read side requests a bank (level)
- iRD_DONE  in  1  one-cycle pulse: read of granted bank finished (read controller done flag)
- oRD_GNT  out  1  read side owns bank oRD_SEL
- oRD_SEL  out  1  bank index granted to read side
- oRD_CLR  out  1  one-cycle pulse coincident with oRD_GNT rising; drives read controller iCLR
- oFULL  out  1  both banks FULL
- oEMPTY  out  1  both banks EMPTY
- oFRAME_CNT  out  FCW  frames consumed, modulo 2^FCW
- oERR  out  1  sticky protocol error

## Operation
- Per-bank state: EMPTY -> WRITING -> FULL -> READING -> EMPTY. No other transitions.
- Pointers wr_ptr and rd_ptr each start at 0 and toggle only on completion. This gives strict ordering: bank 0, 1, 0, 1, ...
- Write grant: when oWR_GNT=0, iWR_REQ=1 and bank[wr_ptr]==EMPTY:
  - bank[wr_ptr] -> WRITING
  - oWR_GNT -> 1, oWR_SEL = wr_ptr
- Write completion: iWR_DONE while oWR_GNT=1:
  - bank -> FULL
  - oWR_GNT -> 0
  - wr_ptr toggles
- Read grant: when oRD_GNT=0, iRD_REQ=1 and bank[rd_ptr]==FULL:
  - bank -> READING
  - oRD_GNT -> 1, oRD_SEL = rd_ptr
  - oRD_CLR pulses
- Read completion: iRD_DONE while oRD_GNT=1:
  - bank -> EMPTY
  - oRD_GNT -> 0
  - rd_ptr toggles
  - oFRAME_CNT increments, wrapping from 2^FCW-1 to 0
- Requests held while already granted are ignored. A request with no eligible bank waits; there is no timeout.
- Protocol errors set oERR and are otherwise ignored, with no state change:
  - iWR_DONE with oWR_GNT=0
  - iRD_DONE with oRD_GNT=0
- oERR clears only on reset or iCLR.
- oFULL and oEMPTY are registered and decoded from next-state bank values.

## Timing
- Reset/iCLR values: all banks EMPTY, pointers 0, oWR_GNT=0, oWR_SEL=0, oRD_GNT=0, oRD_SEL=0, oRD_CLR=0, oFULL=0, oEMPTY=1, oFRAME_CNT=0, oERR=0.
- Grant latency: request sampled high at edge k with the bank eligible → grant high after edge k (visible in cycle k+1).
- Release: DONE sampled at edge k → GNT low in cycle k+1.
- No same-cycle bypass; eligibility uses registered bank state:
  - iWR_DONE on bank b at edge k, iRD_REQ waiting for b → oRD_GNT rises after edge k+1.
  - iRD_DONE on bank b at edge k, iWR_REQ waiting for b → oWR_GNT rises after edge k+1.
- Simultaneous completions on different banks at one edge are both applied.
- iCLR mid-frame: everything returns to reset values at that edge, and any in-flight frame is discarded. iCLR asserted together with DONE: iCLR wins.
- Async reset mid-operation: outputs reset immediately, independent of clock.

## Structure
- Shared package holds:
  - bank state localparams: EMPTY=2'b00, WRITING=2'b01, FULL=2'b10, READING=2'b11
  - bank count constant NBANK=2
- Sub-module bank_state_fsm is instantiated twice, once per bank.
  - Inputs: start_wr, done_wr, start_rd, done_rd, clr.
  - Output: 2-bit state.
- Pointers, grants, frame counter and error flag live in the top level.

## Test plan
- Reset release, iWR_REQ held: oWR_GNT=1 with oWR_SEL=0 in 1st cycle after edge. iWR_DONE → oWR_GNT=0; bank0 FULL.
- Full ping-pong over 4 frames: oWR_SEL and oRD_SEL sequence 0,1,0,1. oRD_CLR is exactly one cycle per grant. oFRAME_CNT=4.
- Writer finishes two frames while reader idle: oFULL=1; 3rd iWR_REQ is not granted until the first iRD_DONE, and then only one cycle later.
- Same-edge iWR_DONE(bank0) with iRD_REQ pending: oRD_GNT rises one cycle later than the write release (no bypass).
- Spurious iRD_DONE with oRD_GNT=0: oERR=1 sticky, oFRAME_CNT unchanged. iCLR → oERR=0 and all reset values.
- FCW=2, run 5 frames: oFRAME_CNT sequence 1,2,3,0,1. Async iRSTn low mid-read: oRD_GNT=0 and oEMPTY=1 immediately.
